// File: rtl/memarb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and grant selector.
package memarb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D} arb_state_t;
  typedef enum {GRANT_I, GRANT_D} arb_grant_t;

  // Width needed to hold a streak count of 0..max.
  function automatic int streak_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/memarb_priority.sv
// Grant selection for the shared memory port: data first, unless fetch has
// waited through D_STREAK_MAX consecutive data grants.
module memarb_priority
  import memarb_pkg::*;
#(
  parameter int D_STREAK_MAX = 4,
  parameter int STREAK_W     = streak_width(D_STREAK_MAX)
) (
  input  logic                i_valid,
  input  logic                d_valid,
  input  logic [STREAK_W-1:0] streak,
  output arb_grant_t          grant
);

  logic fetch_due;

  assign fetch_due = i_valid && (streak == STREAK_W'(D_STREAK_MAX));
  assign grant     = (d_valid && !fetch_due) ? GRANT_D : GRANT_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction in flight. Define MEMARB_STATS_EN to add grant/stall/drop counters.
//
// state      | meaning
// ARB_IDLE   | no transaction outstanding; arbitrate and forward the winner
// ARB_WAIT_I | fetch request accepted by memory; awaiting its response
// ARB_WAIT_D | data request accepted by memory; awaiting its response
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_kill,
  output logic              i_resp_valid,
  output logic [ADDR_W-1:0] i_resp_addr,
  output logic [DATA_W-1:0] i_resp_inst,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_wen,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [ADDR_W-1:0] mem_resp_addr,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_i_stall_cycles,
  output logic [31:0]       stat_drops
`endif
);

  localparam int STREAK_W = streak_width(D_STREAK_MAX);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  arb_grant_t          grant;
  logic                handshake;
  logic                resp_dropped;

  memarb_priority #(
    .D_STREAK_MAX(D_STREAK_MAX),
    .STREAK_W    (STREAK_W)
  ) u_priority (
    .i_valid(i_req_valid),
    .d_valid(d_req_valid),
    .streak (streak_q),
    .grant  (grant)
  );

  assign i_resp_addr  = mem_resp_addr;
  assign i_resp_inst  = mem_resp_rdata;
  assign d_resp_rdata = mem_resp_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    drop_d        = drop_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = i_req_addr;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    i_resp_valid  = 1'b0;
    d_resp_valid  = 1'b0;
    handshake     = 1'b0;
    resp_dropped  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        mem_req_valid = i_req_valid | d_req_valid;
        if (grant == GRANT_D) begin
          mem_req_addr  = d_req_addr;
          mem_req_wen   = d_req_wen;
          mem_req_wdata = d_req_wdata;
          d_req_ready   = mem_req_ready;
        end else begin
          i_req_ready   = mem_req_ready;
        end
        handshake = mem_req_valid && mem_req_ready;
        if (handshake) begin
          if (grant == GRANT_D) begin
            state_d = ARB_WAIT_D;
            // Streak only grows while fetch is actually being held off.
            if (!i_req_valid)
              streak_d = '0;
            else if (streak_q != STREAK_W'(D_STREAK_MAX))
              streak_d = streak_q + STREAK_W'(1);
          end else begin
            state_d  = ARB_WAIT_I;
            streak_d = '0;
            drop_d   = i_kill;
          end
        end
      end
      ARB_WAIT_I: begin
        if (mem_resp_valid) begin
          // A kill coinciding with the response flushes it as well.
          resp_dropped = drop_q || i_kill;
          i_resp_valid = !resp_dropped;
          drop_d       = 1'b0;
          state_d      = ARB_IDLE;
        end else if (i_kill) begin
          drop_d = 1'b1;
        end
      end
      ARB_WAIT_D: begin
        if (mem_resp_valid) begin
          d_resp_valid = 1'b1;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (reset) begin
      mem_req_valid = 1'b0;
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      i_resp_valid  = 1'b0;
      d_resp_valid  = 1'b0;
    end
  end

`ifdef MEMARB_STATS_EN
  logic i_grant_evt, d_grant_evt, i_stall_evt;

  assign i_grant_evt = handshake && (grant == GRANT_I) && !reset;
  assign d_grant_evt = handshake && (grant == GRANT_D) && !reset;
  assign i_stall_evt = i_req_valid && !i_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_i_grants       <= '0;
      stat_d_grants       <= '0;
      stat_i_stall_cycles <= '0;
      stat_drops          <= '0;
    end else begin
      if (i_grant_evt && stat_i_grants != '1)         stat_i_grants       <= stat_i_grants + 32'd1;
      if (d_grant_evt && stat_d_grants != '1)         stat_d_grants       <= stat_d_grants + 32'd1;
      if (i_stall_evt && stat_i_stall_cycles != '1)   stat_i_stall_cycles <= stat_i_stall_cycles + 32'd1;
      if (resp_dropped && stat_drops != '1)           stat_drops          <= stat_drops + 32'd1;
    end
  end
`endif

endmodule
